// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bus: decoder bundle and operands in, registered EX copies,
// load-use stall and bubble statistics out.
interface id_ex_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_AW     = 5,
   parameter int CNT_WIDTH  = 16
);
   logic                  id_valid;
   logic                  id_alusrc;
   logic [1:0]            id_alu_operation;
   logic                  id_memory_read;
   logic                  id_memory_write;
   logic                  id_branch;
   logic                  id_memory_to_register;
   logic                  id_register_write;
   logic [DATA_WIDTH-1:0] id_pc_plus4;
   logic [DATA_WIDTH-1:0] id_read_data1;
   logic [DATA_WIDTH-1:0] id_read_data2;
   logic [DATA_WIDTH-1:0] id_imm_ext;
   logic [REG_AW-1:0]     id_rs;
   logic [REG_AW-1:0]     id_rt;
   logic [REG_AW-1:0]     id_rd;
   logic [5:0]            id_funct;
   logic                  flush;
   logic                  hold;

   logic                  ex_valid;
   logic                  ex_alusrc;
   logic [1:0]            ex_alu_operation;
   logic                  ex_memory_read;
   logic                  ex_memory_write;
   logic                  ex_branch;
   logic                  ex_memory_to_register;
   logic                  ex_register_write;
   logic [DATA_WIDTH-1:0] ex_pc_plus4;
   logic [DATA_WIDTH-1:0] ex_read_data1;
   logic [DATA_WIDTH-1:0] ex_read_data2;
   logic [DATA_WIDTH-1:0] ex_imm_ext;
   logic [REG_AW-1:0]     ex_rs;
   logic [REG_AW-1:0]     ex_rt;
   logic [5:0]            ex_funct;
   logic [REG_AW-1:0]     ex_write_reg;
   logic                  load_use_stall;
   logic [CNT_WIDTH-1:0]  bubble_count;

   modport master (
      output id_valid, id_alusrc, id_alu_operation, id_memory_read, id_memory_write,
             id_branch, id_memory_to_register, id_register_write, id_pc_plus4,
             id_read_data1, id_read_data2, id_imm_ext, id_rs, id_rt, id_rd, id_funct,
             flush, hold,
      input  ex_valid, ex_alusrc, ex_alu_operation, ex_memory_read, ex_memory_write,
             ex_branch, ex_memory_to_register, ex_register_write, ex_pc_plus4,
             ex_read_data1, ex_read_data2, ex_imm_ext, ex_rs, ex_rt, ex_funct,
             ex_write_reg, load_use_stall, bubble_count
   );

   modport slave (
      input  id_valid, id_alusrc, id_alu_operation, id_memory_read, id_memory_write,
             id_branch, id_memory_to_register, id_register_write, id_pc_plus4,
             id_read_data1, id_read_data2, id_imm_ext, id_rs, id_rt, id_rd, id_funct,
             flush, hold,
      output ex_valid, ex_alusrc, ex_alu_operation, ex_memory_read, ex_memory_write,
             ex_branch, ex_memory_to_register, ex_register_write, ex_pc_plus4,
             ex_read_data1, ex_read_data2, ex_imm_ext, ex_rs, ex_rt, ex_funct,
             ex_write_reg, load_use_stall, bubble_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decode bundle, detects lw load-use hazards,
// inserts bubbles on stall/flush/invalid, honours external hold.
module id_ex_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_AW     = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic          clk,
   input  logic          reset,
   id_ex_stage_if.slave  bus
);
   logic              stall;
   logic              kill;
   logic [REG_AW-1:0] wr_next;

   // rt only matters as a source when the ALU takes it (not the immediate)
   assign stall = !reset && bus.ex_valid && bus.ex_memory_read && bus.id_valid &&
                  (bus.ex_rt != '0) &&
                  ((bus.ex_rt == bus.id_rs) || ((bus.ex_rt == bus.id_rt) && !bus.id_alusrc));
   assign bus.load_use_stall = stall;

   // flush beats hold; hold beats stall and invalid-ID bubbles
   assign kill    = bus.flush || (!bus.hold && (stall || !bus.id_valid));
   assign wr_next = (bus.id_alu_operation == 2'b10) ? bus.id_rd : bus.id_rt;

   always_ff @(posedge clk) begin
      if (reset || kill) begin
         bus.ex_valid              <= 1'b0;
         bus.ex_alusrc             <= 1'b0;
         bus.ex_alu_operation      <= 2'b00;
         bus.ex_memory_read        <= 1'b0;
         bus.ex_memory_write       <= 1'b0;
         bus.ex_branch             <= 1'b0;
         bus.ex_memory_to_register <= 1'b0;
         bus.ex_register_write     <= 1'b0;
         bus.ex_pc_plus4           <= {DATA_WIDTH{1'b0}};
         bus.ex_read_data1         <= {DATA_WIDTH{1'b0}};
         bus.ex_read_data2         <= {DATA_WIDTH{1'b0}};
         bus.ex_imm_ext            <= {DATA_WIDTH{1'b0}};
         bus.ex_rs                 <= {REG_AW{1'b0}};
         bus.ex_rt                 <= {REG_AW{1'b0}};
         bus.ex_funct              <= 6'd0;
         bus.ex_write_reg          <= {REG_AW{1'b0}};
      end else if (!bus.hold) begin
         bus.ex_valid              <= 1'b1;
         bus.ex_alusrc             <= bus.id_alusrc;
         bus.ex_alu_operation      <= bus.id_alu_operation;
         bus.ex_memory_read        <= bus.id_memory_read;
         bus.ex_memory_write       <= bus.id_memory_write;
         bus.ex_branch             <= bus.id_branch;
         bus.ex_memory_to_register <= bus.id_memory_to_register;
         bus.ex_register_write     <= bus.id_register_write;
         bus.ex_pc_plus4           <= bus.id_pc_plus4;
         bus.ex_read_data1         <= bus.id_read_data1;
         bus.ex_read_data2         <= bus.id_read_data2;
         bus.ex_imm_ext            <= bus.id_imm_ext;
         bus.ex_rs                 <= bus.id_rs;
         bus.ex_rt                 <= bus.id_rt;
         bus.ex_funct              <= bus.id_funct;
         bus.ex_write_reg          <= wr_next;
      end
   end

   // only hazard bubbles are counted, and only when they actually land in EX
   always_ff @(posedge clk) begin
      if (reset)
         bus.bubble_count <= '0;
      else if (!bus.flush && !bus.hold && stall && (bus.bubble_count != '1))
         bus.bubble_count <= bus.bubble_count + CNT_WIDTH'(1);
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver queues hand-computed expectations,
// a negedge monitor pops and compares. A 2-bit-counter copy checks saturation.
module tb_id_ex_stage;
   typedef struct packed {
      logic valid, alusrc; logic [1:0] op; logic mr, mw, br, m2r, rw;
      logic [31:0] pc, rd1, rd2, imm; logic [4:0] rs, rt, rd; logic [5:0] funct;
   } instr_t;

   typedef struct packed {
      logic valid, alusrc; logic [1:0] op; logic mr, mw, br, m2r, rw;
      logic [31:0] pc, rd1, rd2, imm; logic [4:0] rs, rt; logic [5:0] funct;
      logic [4:0] wr; logic [15:0] cnt; logic [1:0] scnt;
   } ex_t;

   typedef struct {
      int cyc; bit kind; logic stall; ex_t e; string nm;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t mx;
   ex_t  act;
   ex_t  last;

   id_ex_stage_if #(.DATA_WIDTH(32), .REG_AW(5), .CNT_WIDTH(16)) b();
   id_ex_stage_if #(.DATA_WIDTH(32), .REG_AW(5), .CNT_WIDTH(2))  s();

   id_ex_stage #(.DATA_WIDTH(32), .REG_AW(5), .CNT_WIDTH(16)) u_big (.clk(clk), .reset(reset), .bus(b));
   id_ex_stage #(.DATA_WIDTH(32), .REG_AW(5), .CNT_WIDTH(2))  u_sat (.clk(clk), .reset(reset), .bus(s));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic instr_t mk(int tag, logic [1:0] op, logic as, logic mr, logic mw,
                                 logic br, logic m2r, logic rw,
                                 logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
      instr_t i;
      i.valid = 1'b1; i.alusrc = as; i.op = op; i.mr = mr; i.mw = mw; i.br = br;
      i.m2r = m2r; i.rw = rw; i.rs = rs; i.rt = rt; i.rd = rd; i.funct = 6'h20;
      i.pc  = 32'h0040_0000 + 32'(tag * 4);
      i.rd1 = 32'h1111_0000 + 32'(tag);
      i.rd2 = 32'h2222_0000 + 32'(tag);
      i.imm = 32'hFFFF_FF00 + 32'(tag);
      return i;
   endfunction

   function automatic instr_t r_type(int tag, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
      return mk(tag, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rs, rt, rd);
   endfunction

   function automatic instr_t lw(int tag, logic [4:0] rs, logic [4:0] rt);
      return mk(tag, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, rs, rt, 5'd0);
   endfunction

   function automatic instr_t addi(int tag, logic [4:0] rs, logic [4:0] rt);
      return mk(tag, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rs, rt, 5'd0);
   endfunction

   function automatic instr_t rnd();
      instr_t i;
      i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return i;
   endfunction

   function automatic ex_t ld(instr_t i, logic [4:0] wr, logic [15:0] c, logic [1:0] sc);
      ex_t e;
      e.valid = 1'b1; e.alusrc = i.alusrc; e.op = i.op; e.mr = i.mr; e.mw = i.mw;
      e.br = i.br; e.m2r = i.m2r; e.rw = i.rw; e.pc = i.pc; e.rd1 = i.rd1;
      e.rd2 = i.rd2; e.imm = i.imm; e.rs = i.rs; e.rt = i.rt; e.funct = i.funct;
      e.wr = wr; e.cnt = c; e.scnt = sc;
      return e;
   endfunction

   function automatic ex_t bub(logic [15:0] c, logic [1:0] sc);
      ex_t e;
      e = '0; e.cnt = c; e.scnt = sc;
      return e;
   endfunction

   function automatic ex_t snap();
      ex_t a;
      a.valid = b.ex_valid; a.alusrc = b.ex_alusrc; a.op = b.ex_alu_operation;
      a.mr = b.ex_memory_read; a.mw = b.ex_memory_write; a.br = b.ex_branch;
      a.m2r = b.ex_memory_to_register; a.rw = b.ex_register_write;
      a.pc = b.ex_pc_plus4; a.rd1 = b.ex_read_data1; a.rd2 = b.ex_read_data2;
      a.imm = b.ex_imm_ext; a.rs = b.ex_rs; a.rt = b.ex_rt; a.funct = b.ex_funct;
      a.wr = b.ex_write_reg; a.cnt = b.bubble_count; a.scnt = s.bubble_count;
      return a;
   endfunction

   task automatic set_if(input instr_t i, input logic fl, input logic hd);
      b.id_valid = i.valid; b.id_alusrc = i.alusrc; b.id_alu_operation = i.op;
      b.id_memory_read = i.mr; b.id_memory_write = i.mw; b.id_branch = i.br;
      b.id_memory_to_register = i.m2r; b.id_register_write = i.rw;
      b.id_pc_plus4 = i.pc; b.id_read_data1 = i.rd1; b.id_read_data2 = i.rd2;
      b.id_imm_ext = i.imm; b.id_rs = i.rs; b.id_rt = i.rt; b.id_rd = i.rd;
      b.id_funct = i.funct; b.flush = fl; b.hold = hd;
      s.id_valid = i.valid; s.id_alusrc = i.alusrc; s.id_alu_operation = i.op;
      s.id_memory_read = i.mr; s.id_memory_write = i.mw; s.id_branch = i.br;
      s.id_memory_to_register = i.m2r; s.id_register_write = i.rw;
      s.id_pc_plus4 = i.pc; s.id_read_data1 = i.rd1; s.id_read_data2 = i.rd2;
      s.id_imm_ext = i.imm; s.id_rs = i.rs; s.id_rt = i.rt; s.id_rd = i.rd;
      s.id_funct = i.funct; s.flush = fl; s.hold = hd;
   endtask

   // drive one cycle; stall is checked this cycle, EX state after the next edge
   task automatic step(input string nm, input instr_t i, input logic fl, input logic hd,
                       input logic rs, input logic st, input ex_t e);
      @(posedge clk); #1;
      reset = rs;
      set_if(i, fl, hd);
      q.push_back('{cyc, 1'b0, st, e, nm});
      q.push_back('{cyc + 1, 1'b1, st, e, nm});
      last = e;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         mx = q.pop_front();
         checks++;
         if (mx.cyc < cyc) begin
            errors++;
            $display("FAIL %s late: checked at cycle %0d, required at %0d", mx.nm, cyc, mx.cyc);
         end else if (mx.kind == 1'b0) begin
            if (b.load_use_stall !== mx.stall) begin
               errors++;
               $display("FAIL %s_stall: got %b expected %b", mx.nm, b.load_use_stall, mx.stall);
            end
         end else begin
            act = snap();
            if (act !== mx.e) begin
               errors++;
               $display("FAIL %s_ex: got %h expected %h", mx.nm, act, mx.e);
            end
         end
      end
   end

   initial begin
      instr_t l, a;
      ex_t    held;
      set_if(rnd(), 1'b0, 1'b0);
      step("rst0", rnd(), 1'b0, 1'b0, 1'b1, 1'b0, bub(0, 0));
      step("rst1", rnd(), 1'b1, 1'b1, 1'b1, 1'b0, bub(0, 0));

      a = r_type(1, 5'd1, 5'd2, 5'd3);
      step("rtype", a, 0, 0, 0, 0, ld(a, 5'd3, 0, 0));

      l = lw(2, 5'd1, 5'd5);
      step("lw", l, 0, 0, 0, 0, ld(l, 5'd5, 0, 0));
      a = r_type(3, 5'd5, 5'd6, 5'd7);
      step("luse_rs", a, 0, 0, 0, 1, bub(1, 1));
      step("luse_go", a, 0, 0, 0, 0, ld(a, 5'd7, 1, 1));

      l = lw(4, 5'd2, 5'd0);
      step("lw_r0", l, 0, 0, 0, 0, ld(l, 5'd0, 1, 1));
      a = r_type(5, 5'd0, 5'd0, 5'd4);
      step("r0_dep", a, 0, 0, 0, 0, ld(a, 5'd4, 1, 1));
      l = lw(6, 5'd1, 5'd5);
      step("lw5", l, 0, 0, 0, 0, ld(l, 5'd5, 1, 1));
      a = addi(7, 5'd1, 5'd5);
      step("addi_imm", a, 0, 0, 0, 0, ld(a, 5'd5, 1, 1));

      l = lw(8, 5'd1, 5'd9);
      step("lw9", l, 0, 0, 0, 0, ld(l, 5'd9, 1, 1));
      a = r_type(9, 5'd4, 5'd9, 5'd10);
      step("luse_rt", a, 0, 0, 0, 1, bub(2, 2));
      step("luse_rt_go", a, 0, 0, 0, 0, ld(a, 5'd10, 2, 2));

      step("flush_hold", r_type(10, 5'd1, 5'd2, 5'd3), 1, 1, 0, 0, bub(2, 2));
      a = r_type(11, 5'd8, 5'd9, 5'd10);
      step("load_h", a, 0, 0, 0, 0, ld(a, 5'd10, 2, 2));
      held = last;
      for (int k = 0; k < 3; k++)
         step("hold", r_type(12 + k, 5'd3, 5'd4, 5'd5), 0, 1, 0, 0, held);

      a = mk(15, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 5'd0);
      step("sw", a, 0, 0, 0, 0, ld(a, 5'd4, 2, 2));
      a = mk(16, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 5'd4, 5'd0);
      step("beq", a, 0, 0, 0, 0, ld(a, 5'd4, 2, 2));
      a = r_type(17, 5'd1, 5'd2, 5'd3);
      a.valid = 1'b0;
      step("invalid", a, 0, 0, 0, 0, bub(2, 2));

      l = lw(18, 5'd1, 5'd5);
      step("lw18", l, 0, 0, 0, 0, ld(l, 5'd5, 2, 2));
      a = r_type(19, 5'd5, 5'd1, 5'd2);
      step("hold_stall", a, 0, 1, 0, 1, ld(l, 5'd5, 2, 2));
      step("stall3", a, 0, 0, 0, 1, bub(3, 3));
      step("stall3_go", a, 0, 0, 0, 0, ld(a, 5'd2, 3, 3));

      l = lw(20, 5'd1, 5'd6);
      step("lw20", l, 0, 0, 0, 0, ld(l, 5'd6, 3, 3));
      a = r_type(21, 5'd6, 5'd0, 5'd1);
      step("flush_stall", a, 1, 0, 0, 1, bub(3, 3));
      step("flush_go", a, 0, 0, 0, 0, ld(a, 5'd1, 3, 3));

      l = lw(22, 5'd1, 5'd7);
      step("lw22", l, 0, 0, 0, 0, ld(l, 5'd7, 3, 3));
      a = r_type(23, 5'd7, 5'd7, 5'd8);
      step("sat4", a, 0, 0, 0, 1, bub(4, 3));
      step("sat4_go", a, 0, 0, 0, 0, ld(a, 5'd8, 4, 3));
      l = lw(24, 5'd1, 5'd8);
      step("lw24", l, 0, 0, 0, 0, ld(l, 5'd8, 4, 3));
      a = r_type(25, 5'd2, 5'd8, 5'd9);
      step("sat5", a, 0, 0, 0, 1, bub(5, 3));
      step("sat5_go", a, 0, 0, 0, 0, ld(a, 5'd9, 5, 3));

      l = lw(26, 5'd1, 5'd3);
      step("lw26", l, 0, 0, 0, 0, ld(l, 5'd3, 5, 3));
      a = r_type(27, 5'd3, 5'd0, 5'd1);
      step("rst_stall", a, 0, 0, 1, 0, bub(0, 0));
      step("after_rst", a, 0, 0, 0, 0, ld(a, 5'd1, 0, 0));

      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
